unidade_controle: RTL
=====================

Name: unidade_controle

Overview:
- Multicycle instruction sequencer that sits directly upstream of banco_registradores and drives its ports.
- Accepts one 16-bit instruction per valid/ready handshake.
- Drives Read1/Read2, captures Data1/Data2, computes the result in an internal ULA, and writes the result back through WriteReg/WriteData/RegWrite.
- Processes one instruction at a time; four cycles per instruction.

Parameters:
- LARGURA, 16, data word width; must match banco_registradores.
- BITS_REG, 3, register address width (8 registers).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- instr_valid  input  1  upstream has an instruction on instr.
- instr_ready  output  1  block can accept an instruction.
- instr  input  16  instruction word.
- Read1  output  3  register address for banco_registradores port 1 (rs).
- Read2  output  3  register address for banco_registradores port 2 (rt).
- Data1  input  16  value returned for Read1.
- Data2  input  16  value returned for Read2.
- WriteReg  output  3  destination register (rd).
- WriteData  output  16  result to be written.
- RegWrite  output  1  write enable to banco_registradores.
- concluido  output  1  one-cycle pulse when an instruction retires.
- op_invalida  output  1  one-cycle pulse, coincident with concluido, when the retired opcode was undefined.

Behaviour:
- Instruction format: op=instr[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm6=[5:0], imm9=[8:0].
- Opcodes:
  - 0000 NOP
  - 0001 ADD rd=rs+rt
  - 0010 SUB rd=rs-rt
  - 0011 AND
  - 0100 OR
  - 0101 SLT rd=(signed rs<signed rt)?1:0
  - 0110 ADDI rd=rs+sext(imm6)
  - 0111 MVI rd=zext(imm9)
  - 1000 MUL (optional feature only)
  - All others undefined.
- Arithmetic: modulo 2^16; no overflow flag or carry output.
- FSM states: OCIOSO -> LEITURA -> EXECUTA -> ESCRITA -> OCIOSO.
- OCIOSO:
  - instr_ready=1.
  - When instr_valid=1, the instruction is latched into an internal register and the FSM moves to LEITURA.
  - instr_ready is 0 in every other state.
- LEITURA:
  - Read1=rs and Read2=rt come from the latched instruction.
  - Data1/Data2 are captured at the end of the cycle; banco_registradores reads are combinational.
- EXECUTA: the ULA result is registered.
- ESCRITA:
  - RegWrite=1 for exactly this cycle, unless the opcode is NOP or undefined.
  - WriteReg=rd, WriteData=result; concluido=1.
  - op_invalida=1 if the opcode is undefined.
- Latency:
  - Handshake at cycle T; RegWrite high during T+3; the register file updates at the edge ending T+3.
  - The next instruction can be accepted at T+4.
  - Throughput is 1 instruction per 4 cycles.
- Read1, Read2, WriteReg and WriteData hold their last values outside their active states. RegWrite, concluido and op_invalida are 0 outside ESCRITA.
- Writes to register 0 are legal; there is no hardwired zero register.
- rd equal to rs/rt: operands were captured in LEITURA, so the old value is used.
- Reset values:
  - FSM = OCIOSO; instr_ready=1 after reset.
  - Read1, Read2, WriteReg = 0; WriteData = 0.
  - RegWrite, concluido, op_invalida = 0.
- Reset mid-operation: the asserting edge of resetn immediately forces RegWrite=0 and OCIOSO. The in-flight instruction is discarded and no write occurs.
- instr_valid in a non-OCIOSO state is ignored; upstream must hold instr until handshake.

Optional Feature:
- Macro: UNIDADE_CONTROLE_MUL_EN.
- When defined: opcode 1000 is MUL, rd=low 16 bits of rs*rt (unsigned).
- When undefined: 1000 is undefined (no write, op_invalida pulse), and no multiplier is synthesised.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_NOP..OP_MUL).
  - FSM state encoding (2 bits).
  - Instruction field bit positions.
  - LARGURA/BITS_REG defaults.
- One natural sub-module: ula (combinational; inputs a, b, imm, op; output resultado).
- unidade_controle holds the FSM, instruction register, operand registers and result register.

Test Plan:
- Send MVI r1,5; MVI r2,3; ADD r3,r1,r2 (0x1650) -> ADD handshake at T, RegWrite=1 at T+3 with WriteReg=3, WriteData=0x0008, concluido=1.
- SUB r4,r2,r1 -> WriteData=0xFFFE. Then SLT r5,r4,r1 -> WriteData=0x0001 (signed -2<5). Then ADDI r6,r1,imm6=0x3F -> WriteData=0x0004.
- instr=0xF000 (undefined) -> RegWrite stays 0; concluido=1 and op_invalida=1 at T+3. NOP -> concluido=1, op_invalida=0, no write.
- instr_valid held high with a stream of 3 instructions -> instr_ready high only 1 cycle in 4; exactly 3 RegWrite pulses, in order.
- Drop resetn during EXECUTA of ADD r7,r1,r2 -> RegWrite never asserts for it. After release, instr_ready=1 and the register file is unchanged.
- With UNIDADE_CONTROLE_MUL_EN: r1=300, r2=3, MUL -> WriteData=0x0384. Without it: same instruction -> op_invalida=1, no write.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// Shared constants for the unidade_controle sequencer and its ULA.
// Build option: UNIDADE_CONTROLE_MUL_EN enables opcode 1000 (MUL).
package unidade_controle_pkg;

  localparam int LARGURA_PAD  = 16;
  localparam int BITS_REG_PAD = 3;

  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_LSB  = 3;
  localparam int IMM6_W  = 6;
  localparam int IMM9_W  = 9;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h5;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OP_W-1:0] OP_MVI  = 4'h7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    EXECUTA = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

  function automatic logic op_definida(
    input logic [OP_W-1:0] op
  );
`ifdef UNIDADE_CONTROLE_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_MVI;
`endif
  endfunction

  function automatic logic op_escreve(
    input logic [OP_W-1:0] op
  );
    return op_definida(op) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/unidade_controle_ula.sv
// Combinational ULA for unidade_controle.
// MUL exists only with UNIDADE_CONTROLE_MUL_EN defined.
module ula
  import unidade_controle_pkg::*;
#(
  parameter int LARGURA = LARGURA_PAD
) (
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic [IMM9_W-1:0]  imm,
  input  logic [OP_W-1:0]    op,
  output logic [LARGURA-1:0] resultado
);

  logic [LARGURA-1:0] w_imm6_sx;
  logic [LARGURA-1:0] w_imm9_zx;
  logic               w_menor;

  assign w_imm6_sx = {{(LARGURA-IMM6_W){imm[IMM6_W-1]}},
                      imm[IMM6_W-1:0]};
  assign w_imm9_zx = {{(LARGURA-IMM9_W){1'b0}}, imm};
  assign w_menor   = $signed(a) < $signed(b);

  // Opcode select; NOP and undefined codes yield zero.
  always_comb begin
    resultado = '0;
    unique case (1'b1)
      (op == OP_ADD):  resultado = a + b;
      (op == OP_SUB):  resultado = a - b;
      (op == OP_AND):  resultado = a & b;
      (op == OP_OR):   resultado = a | b;
      (op == OP_SLT):  resultado = {{(LARGURA-1){1'b0}}, w_menor};
      (op == OP_ADDI): resultado = a + w_imm6_sx;
      (op == OP_MVI):  resultado = w_imm9_zx;
`ifdef UNIDADE_CONTROLE_MUL_EN
      (op == OP_MUL):  resultado = a * b;
`endif
      default:         resultado = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Four-cycle instruction sequencer driving banco_registradores.
// Build option: UNIDADE_CONTROLE_MUL_EN adds MUL (opcode 1000).
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PAD,
  parameter int BITS_REG = BITS_REG_PAD
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr,
  output logic [BITS_REG-1:0] Read1,
  output logic [BITS_REG-1:0] Read2,
  input  logic [LARGURA-1:0]  Data1,
  input  logic [LARGURA-1:0]  Data2,
  output logic [BITS_REG-1:0] WriteReg,
  output logic [LARGURA-1:0]  WriteData,
  output logic                RegWrite,
  output logic                concluido,
  output logic                op_invalida
);

  estado_t             r_estado;
  logic [INSTR_W-1:0]  r_instr;
  logic [LARGURA-1:0]  r_dado1;
  logic [LARGURA-1:0]  r_dado2;
  logic [LARGURA-1:0]  r_resultado;
  logic [BITS_REG-1:0] r_read1;
  logic [BITS_REG-1:0] r_read2;
  logic [BITS_REG-1:0] r_write_reg;
  logic                r_ready;
  logic                r_reg_write;
  logic                r_concluido;
  logic                r_op_invalida;

  logic [OP_W-1:0]     w_op;
  logic [LARGURA-1:0]  w_ula;

  assign w_op = r_instr[OP_LSB +: OP_W];

  ula #(
    .LARGURA (LARGURA)
  ) u_ula (
    .a         (r_dado1),
    .b         (r_dado2),
    .imm       (r_instr[IMM9_W-1:0]),
    .op        (w_op),
    .resultado (w_ula)
  );

  // Sequencer: accept, read operands, execute, retire.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_estado      <= OCIOSO;
      r_instr       <= '0;
      r_dado1       <= '0;
      r_dado2       <= '0;
      r_resultado   <= '0;
      r_read1       <= '0;
      r_read2       <= '0;
      r_write_reg   <= '0;
      r_ready       <= 1'b1;
      r_reg_write   <= 1'b0;
      r_concluido   <= 1'b0;
      r_op_invalida <= 1'b0;
    end else begin
      r_reg_write   <= 1'b0;
      r_concluido   <= 1'b0;
      r_op_invalida <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (instr_valid) begin
            r_instr  <= instr;
            r_read1  <= instr[RS_LSB +: BITS_REG];
            r_read2  <= instr[RT_LSB +: BITS_REG];
            r_ready  <= 1'b0;
            r_estado <= LEITURA;
          end
        end
        LEITURA: begin
          r_dado1  <= Data1;
          r_dado2  <= Data2;
          r_estado <= EXECUTA;
        end
        EXECUTA: begin
          r_resultado   <= w_ula;
          r_write_reg   <= r_instr[RD_LSB +: BITS_REG];
          r_reg_write   <= op_escreve(w_op);
          r_concluido   <= 1'b1;
          r_op_invalida <= !op_definida(w_op);
          r_estado      <= ESCRITA;
        end
        ESCRITA: begin
          r_ready  <= 1'b1;
          r_estado <= OCIOSO;
        end
        default: begin
          r_ready  <= 1'b1;
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign Read1       = r_read1;
  assign Read2       = r_read2;
  assign WriteReg    = r_write_reg;
  assign WriteData   = r_resultado;
  assign RegWrite    = r_reg_write;
  assign concluido   = r_concluido;
  assign op_invalida = r_op_invalida;

endmodule
